// File: rtl/side_panel_renderer_if.sv
// rtl/side_panel_renderer_if.sv - pixel position, game state, ROM and colour bundle for one side panel
interface side_panel_renderer_if #(
    parameter int ADDR_W = 19
);
    logic [10:0]       pos_x;
    logic [10:0]       pos_y;
    logic [2:0]        state;
    logic              frame_start;
    logic [11:0]       fg_color;
    logic [11:0]       bg_color;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_data;
    logic [3:0]        pix_r;
    logic [3:0]        pix_g;
    logic [3:0]        pix_b;
    logic              pix_valid;

    modport master (
        output pos_x, pos_y, state, frame_start, fg_color, bg_color, rom_data,
        input  rom_addr, pix_r, pix_g, pix_b, pix_valid
    );

    modport slave (
        input  pos_x, pos_y, state, frame_start, fg_color, bg_color, rom_data,
        output rom_addr, pix_r, pix_g, pix_b, pix_valid
    );
endinterface

// File: rtl/side_panel_renderer.sv
// rtl/side_panel_renderer.sv - 1-bpp ROM bitmap panel renderer with scroll/blink modes
module side_panel_renderer #(
    parameter int         X0           = 0,
    parameter int         Y0           = 100,
    parameter int         W            = 350,
    parameter int         H            = 800,
    parameter int         ADDR_W       = 19,
    parameter int         ROM_LAT      = 1,
    parameter int         SCROLL_STEP  = 1,
    parameter int         BLINK_FRAMES = 32,
    parameter logic [2:0] ST_RUN       = 3'd1,
    parameter logic [2:0] ST_OVER      = 3'd2
) (
    input logic                  clk,
    input logic                  rst_n,
    side_panel_renderer_if.slave bus
);
    localparam int             BW     = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0]  B_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [12:0]    H13    = 13'(H);
    localparam logic [11:0]    H12    = 12'(H);
    localparam logic [11:0]    STEP12 = 12'(SCROLL_STEP);

    typedef enum logic [1:0] {MODE_IDLE, MODE_RUN, MODE_OVER} mode_e;

    mode_e              mode;
    logic [12:0]        dx, dy, row_raw, row;
    logic [11:0]        scroll_sum;
    logic               in_region;
    logic [11:0]        fg_eff;

    logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
    logic [11:0]        scroll_off_d, scroll_off_q;
    logic [BW-1:0]      blink_cnt_d, blink_cnt_q;
    logic               blink_on_d, blink_on_q;
    logic [ROM_LAT:0]   vld_d, vld_q, blk_d, blk_q;
    logic [11:0]        pix_d, pix_q;
    logic               pix_valid_d, pix_valid_q;

    always_comb begin
        // Positions left of/above the origin wrap to huge 13-bit offsets, so one
        // unsigned compare per axis covers both bounds without a ">= 0" test.
        dx        = {2'b00, bus.pos_x} - 13'(X0);
        dy        = {2'b00, bus.pos_y} - 13'(Y0);
        in_region = (dx < 13'(W)) && (dy < 13'(H));

        row_raw    = dy + {1'b0, scroll_off_q};
        row        = (row_raw >= H13) ? row_raw - H13 : row_raw;
        rom_addr_d = in_region ? ADDR_W'(row) * ADDR_W'(W) + ADDR_W'(dx) : rom_addr_q;

        vld_d = {vld_q[ROM_LAT-1:0], in_region};
        blk_d = {blk_q[ROM_LAT-1:0], blink_on_q};

        fg_eff      = blk_q[ROM_LAT] ? bus.fg_color : bus.bg_color;
        pix_valid_d = vld_q[ROM_LAT];
        pix_d       = pix_valid_d ? (bus.rom_data ? fg_eff : bus.bg_color) : 12'h000;

        if (bus.state == ST_RUN)       mode = MODE_RUN;
        else if (bus.state == ST_OVER) mode = MODE_OVER;
        else                           mode = MODE_IDLE;

        scroll_sum = scroll_off_q + STEP12;
        if (scroll_sum >= H12) scroll_sum = scroll_sum - H12;

        scroll_off_d = scroll_off_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        // Mode registers only move at frame boundaries so a frame never tears.
        if (bus.frame_start) begin
            case (mode)
                MODE_RUN: begin
                    scroll_off_d = scroll_sum;
                    blink_cnt_d  = '0;
                    blink_on_d   = 1'b1;
                end
                MODE_OVER: begin
                    if (blink_cnt_q == B_LAST) begin
                        blink_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
                default: begin
                    scroll_off_d = '0;
                    blink_cnt_d  = '0;
                    blink_on_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q   <= '0;
            scroll_off_q <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            vld_q        <= '0;
            blk_q        <= '0;
            pix_q        <= '0;
            pix_valid_q  <= 1'b0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            scroll_off_q <= scroll_off_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            vld_q        <= vld_d;
            blk_q        <= blk_d;
            pix_q        <= pix_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pix_r     = pix_q[11:8];
    assign bus.pix_g     = pix_q[7:4];
    assign bus.pix_b     = pix_q[3:0];
    assign bus.pix_valid = pix_valid_q;
endmodule

// File: doc/side_panel_renderer.md
Name: side_panel_renderer

Overview:
- Parametrised successor to the fixed left side-bar renderer: draws a 1-bpp bitmap panel, read from an external ROM, into a rectangular screen region, with run-time foreground/background colours.
- Adds parametrised origin and size, a latency-matched pipeline so the region flag and pixel colour stay aligned with ROM latency, and game-state modes: vertical scroll while running, blink on game over.
- Sits between the VGA timing generator (pos_x/pos_y) and the top-level pixel mux; one instance per side panel.

Parameters:
- X0, 0, left column of region (inclusive)
- Y0, 100, top row of region (inclusive)
- W, 350, region width in pixels
- H, 800, region height in pixels
- ADDR_W, 19, ROM address width; W*H <= 2^ADDR_W
- ROM_LAT, 1, ROM read latency in clocks (>= 1)
- SCROLL_STEP, 1, rows advanced per frame in RUN; must be < H
- BLINK_FRAMES, 32, frames per blink half-period
- ST_RUN, 3'd1, state code for running
- ST_OVER, 3'd2, state code for game over

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pos_x  in  11  current pixel column
- pos_y  in  11  current pixel row
- state  in  3  game state
- frame_start  in  1  one-cycle pulse before the first pixel of each frame
- fg_color  in  12  RGB444 colour for ROM bit 1
- bg_color  in  12  RGB444 colour for ROM bit 0
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  1  ROM data, valid ROM_LAT clocks after rom_addr
- pix_r  out  4  red
- pix_g  out  4  green
- pix_b  out  4  blue
- pix_valid  out  1  region flag, aligned with pix_r/g/b

Behaviour:
- Reset (async assert, sync release): rom_addr=0, pix_r/g/b=0, pix_valid=0, scroll_off=0, blink_cnt=0, blink_on=1, all pipeline valid bits=0.
- In-region test: X0 <= pos_x < X0+W and Y0 <= pos_y < Y0+H, computed at full 11-bit width with no wrap; X0=0 must not produce a negative-compare bug.
- Stage 0, registered at cycle t+1:
  - rom_addr = row*W + (pos_x - X0), where row = (pos_y - Y0) + scroll_off, minus H if >= H. Row is at most 2H-2 before reduction; intermediate is 12 bits.
  - in-region bit captured into the pipeline.
  - Outside the region: rom_addr holds its previous value.
- In-region bit and pixel-mode bits are delayed ROM_LAT cycles to match rom_data.
- Final stage: pixel = rom_data ? fg_eff : bg_color; fg_eff = bg_color when blink is off, else fg_color. pix_valid = delayed in-region bit; RGB forced to 0 when not valid.
- Total latency: pos -> pix = 2 + ROM_LAT clocks, fixed, no bubbles; one pixel per clock.
- Colour inputs are sampled at the final stage, so colour changes take effect on the next output pixel.
- Mode FSM, evaluated only on frame_start using the state sampled that cycle:
  - RUN (state==ST_RUN): scroll_off = (scroll_off + SCROLL_STEP) mod H; blink_cnt=0; blink_on=1.
  - OVER (state==ST_OVER): scroll_off frozen. blink_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - IDLE (any other code): scroll_off=0, blink_cnt=0, blink_on=1.
- scroll_off and blink_on change only on frame_start, never mid-frame, so there is no tearing.
- A state change without frame_start has no effect until the next frame_start.
- frame_start asserted during an in-region pixel: the pixel already in the pipeline uses its old values; pixels entering stage 0 from the next cycle use the new values.
- Reset mid-frame: outputs go to 0 immediately. After release, output is valid from the first pixel entering stage 0, i.e. after 2+ROM_LAT clocks.

Test Plan:
- Reset with rom_data tied 1, then scan a pixel at (X0-1,Y0), (X0,Y0) and (X0+W,Y0) -> pix_valid 0,1,0 exactly 2+ROM_LAT clocks later; rom_addr=0 for (X0,Y0).
- IDLE, pixel (X0+5,Y0+2), ROM model returns bit 1, fg=12'hfff, bg=12'h213 -> rom_addr=2*W+5=705; output RGB = f,f,f; with bit 0 -> 2,1,3.
- RUN, 3 frame_start pulses with SCROLL_STEP=1, pixel (X0,Y0+H-1) -> scroll_off=3, row wraps to 2, rom_addr=2*W=700.
- OVER, BLINK_FRAMES=4, 8 frame_start pulses with ROM bit 1, fg=fff, bg=000 -> output fff for frames 1-3, 000 for frames 4-7, fff from frame 8; scroll_off unchanged.
- Return to IDLE plus a frame_start -> scroll_off=0, blink_on=1; rerun with ROM_LAT=3 -> all alignment checks still hold at latency 5.
- Assert rst_n low mid-region for 2 clocks -> pix_r/g/b and pix_valid drop to 0 asynchronously; after release, first valid output appears exactly 2+ROM_LAT clocks after the first in-region pixel.
